ctrl_pipeline: RTL and testbench
================================

Name: ctrl_pipeline

Overview:
- Pipelined control-signal carrier and hazard unit, directly downstream of the decode-stage main controller.
- Latches the controller's decoded control outputs plus register indices into ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles; applies taken-branch/jump flushes.
- Produces EX-stage forwarding selects and saturating stall/flush event counters for the datapath.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 16, width of each hazard event counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_jsel  in  1 each  decode-stage control bits from the controller.
- id_aluop  in  2  controller ALUOp: 00 LW/SW, 01 branch, 10 R/I-type, 11 LUI.
- id_rs1, id_rs2, id_rd  in  REG_AW each  decode-stage register indices.
- ex_redirect  in  1  EX-stage branch taken or jump resolved this cycle.
- ex_alusrc, ex_branch, ex_jsel, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  out  1 each  ID/EX control.
- ex_aluop  out  2  ID/EX ALUOp.
- ex_rs1, ex_rs2, ex_rd  out  REG_AW each  ID/EX indices.
- mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out  1 each  EX/MEM control.
- mem_rd  out  REG_AW  EX/MEM destination.
- wb_regwrite, wb_memtoreg  out  1 each  MEM/WB control.
- wb_rd  out  REG_AW  MEM/WB destination.
- stall  out  1  combinational: hold PC and IF/ID.
- flush  out  1  combinational: clear IF/ID.
- fwd_a, fwd_b  out  2 each  combinational: EX operand source select.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (reset=0, asynchronous): every registered output and both counters go to 0. All three stages then hold a bubble (all control bits 0, all indices 0).
- Load-use detect: hz = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- flush = ex_redirect.
- stall = hz & ~ex_redirect. A redirect overrides a stall because the dependent instruction is being discarded anyway.
- ID/EX update on each rising edge:
  - If ex_redirect or hz: load a bubble.
  - Otherwise: load the id_* bundle.
  - Latency from decode to EX is 1 cycle.
- EX/MEM and MEM/WB always advance every cycle and are never stalled or flushed. A bubble propagates down the stages as zeros.
- Flush scope: only ID/EX is cleared here; IF/ID clearing is the fetch stage's job, driven by flush. A redirect never clears EX/MEM, because the branch itself moves on to MEM.
- fwd_a priority (evaluated against ex_rs1; fwd_b identical against ex_rs2):
  - 2'b10 if mem_regwrite & (mem_rd != 0) & (mem_rd == ex_rs1).
  - else 2'b01 if wb_regwrite & (wb_rd != 0) & (wb_rd == ex_rs1).
  - else 2'b00.
- Register x0 never causes a stall or a forward. A RegWrite with rd = 0 still propagates unchanged.
- stall_cnt increments by 1 on each edge where stall=1; flush_cnt increments on each edge where flush=1. Both saturate at all-ones with no wrap.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The first edge after reset deasserts loads the id_* bundle normally.
- Back-to-back load-use: stall lasts exactly 1 cycle per hazard, because the bubble clears ex_memread.

Decomposition:
- Package ctrl_pipeline_pkg holds:
  - Typedefs ex_ctrl_t, mem_ctrl_t, wb_ctrl_t (packed structs of the bits above).
  - Constant BUBBLE for each struct (all zeros).
  - Constants FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Constants ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_LUI.
- Sub-module forwarding_unit: purely combinational, produces fwd_a/fwd_b from the ex/mem/wb indices and regwrite bits. It is verified separately.

Test Plan:
- Load-use: lw x5 in EX (ex_memread=1, ex_rd=5), add in ID with id_rs2=5 -> stall=1 for 1 cycle; next cycle ex_* all 0; stall_cnt goes 0 -> 1.
- Forward priority: mem_rd=7 and wb_rd=7 both writing, ex_rs1=7 -> fwd_a=2'b10. With mem_regwrite=0 -> fwd_a=2'b01. ex_rs2=3 with no matching writer -> fwd_b=2'b00.
- x0: ex_memread=1, ex_rd=0, id_rs1=0 -> stall=0. mem_rd=0, mem_regwrite=1, ex_rs1=0 -> fwd_a=2'b00.
- Redirect + hazard in the same cycle -> flush=1, stall=0; ID/EX gets a bubble; flush_cnt increments, stall_cnt unchanged; mem_* still takes the previous ex_* values.
- Reset mid-stream: pipeline full of R-type writes to rd=9, reset pulled low between edges -> all outputs 0 immediately. After release, id bundle (regwrite=1, rd=9) reaches ex_rd=9 after 1 edge, mem_rd after 2 edges, wb_rd after 3 edges.
- Counter saturation: CNT_W=4, hold the hazard condition (re-presenting the load each cycle) for 20 stall events -> stall_cnt stays at 4'hF, no wrap.

Source files
------------

// File: rtl/ctrl_pipeline_pkg.sv
// ctrl_pipeline_pkg
// Shared types and constants for the control pipeline and hazard unit.
//   ex_ctrl_t  - control bits consumed in EX (ALU source, ALUOp, branch/jump)
//   mem_ctrl_t - control bits consumed in MEM (load/store)
//   wb_ctrl_t  - control bits consumed in WB (register write, result select)
//   *_BUBBLE   - all-zero bundles injected on stalls, flushes and reset
//   FWD_*      - EX operand source select encodings
//   ALUOP_*    - controller ALUOp encodings
package ctrl_pipeline_pkg;

  typedef struct packed {
    logic       alusrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jsel;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_LUI = 2'b11;

endpackage

// File: rtl/ctrl_pipeline_forwarding_unit.sv
// forwarding_unit
// Purely combinational EX-stage operand forwarding select.
// Ports:
//   ex_rs1, ex_rs2   in   source indices of the instruction in EX
//   mem_rd           in   destination of the instruction in MEM
//   mem_regwrite     in   MEM instruction writes a register
//   wb_rd            in   destination of the instruction in WB
//   wb_regwrite      in   WB instruction writes a register
//   fwd_a, fwd_b     out  source select for operand A / B (FWD_* encoding)
module forwarding_unit
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // The younger result (MEM) wins over the older one (WB); x0 is hardwired
  // to zero so it is never a forwarding source.
  function automatic logic [1:0] select_src(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))
      sel = FWD_MEM;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    fwd_a = select_src(ex_rs1);
    fwd_b = select_src(ex_rs2);
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Carries decoded control bits and register indices through ID/EX, EX/MEM
// and MEM/WB, detects load-use hazards, applies redirect flushes, produces
// EX forwarding selects and counts stall/flush events.
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   id_*                  decode-stage control bits and register indices
//   ex_redirect           EX-stage branch taken / jump resolved this cycle
//   ex_*                  ID/EX control and indices
//   mem_*                 EX/MEM control and destination
//   wb_*                  MEM/WB control and destination
//   stall, flush          combinational hold-PC/IF-ID and clear-IF-ID
//   fwd_a, fwd_b          combinational EX operand source selects
//   stall_cnt, flush_cnt  saturating event counters
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_branch,
  input  logic              id_jsel,
  input  logic [1:0]        id_aluop,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_redirect,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_jsel,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic [1:0]        ex_aluop,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_regwrite,
  output logic              mem_memtoreg,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ex_ctrl_t  id_ex_c, ex_ex_c;
  mem_ctrl_t id_mem_c, ex_mem_c, mem_mem_c;
  wb_ctrl_t  id_wb_c, ex_wb_c, mem_wb_c, wb_wb_c;

  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
  logic              hz;
  logic              bubble_ex;

  assign id_ex_c  = '{alusrc: id_alusrc, aluop: id_aluop, branch: id_branch, jsel: id_jsel};
  assign id_mem_c = '{memread: id_memread, memwrite: id_memwrite};
  assign id_wb_c  = '{regwrite: id_regwrite, memtoreg: id_memtoreg};

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; x0 is excluded because it is never really written.
  assign hz = ex_mem_c.memread && (ex_rd_q != '0) &&
              ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

  // A redirect discards the instruction in ID, so it overrides the stall.
  assign flush     = ex_redirect;
  assign stall     = hz && !ex_redirect;
  assign bubble_ex = ex_redirect || hz;

  // ID/EX takes a bubble on hazard or redirect; the later stages always
  // advance so the branch itself and older instructions keep moving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ex_c   <= EX_BUBBLE;
      ex_mem_c  <= MEM_BUBBLE;
      ex_wb_c   <= WB_BUBBLE;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_rd_q   <= '0;
      mem_mem_c <= MEM_BUBBLE;
      mem_wb_c  <= WB_BUBBLE;
      mem_rd_q  <= '0;
      wb_wb_c   <= WB_BUBBLE;
      wb_rd_q   <= '0;
    end else begin
      if (bubble_ex) begin
        ex_ex_c  <= EX_BUBBLE;
        ex_mem_c <= MEM_BUBBLE;
        ex_wb_c  <= WB_BUBBLE;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
        ex_rd_q  <= '0;
      end else begin
        ex_ex_c  <= id_ex_c;
        ex_mem_c <= id_mem_c;
        ex_wb_c  <= id_wb_c;
        ex_rs1_q <= id_rs1;
        ex_rs2_q <= id_rs2;
        ex_rd_q  <= id_rd;
      end
      mem_mem_c <= ex_mem_c;
      mem_wb_c  <= ex_wb_c;
      mem_rd_q  <= ex_rd_q;
      wb_wb_c   <= mem_wb_c;
      wb_rd_q   <= mem_rd_q;
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign ex_alusrc    = ex_ex_c.alusrc;
  assign ex_aluop     = ex_ex_c.aluop;
  assign ex_branch    = ex_ex_c.branch;
  assign ex_jsel      = ex_ex_c.jsel;
  assign ex_memread   = ex_mem_c.memread;
  assign ex_memwrite  = ex_mem_c.memwrite;
  assign ex_regwrite  = ex_wb_c.regwrite;
  assign ex_memtoreg  = ex_wb_c.memtoreg;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign mem_memread  = mem_mem_c.memread;
  assign mem_memwrite = mem_mem_c.memwrite;
  assign mem_regwrite = mem_wb_c.regwrite;
  assign mem_memtoreg = mem_wb_c.memtoreg;
  assign mem_rd       = mem_rd_q;
  assign wb_regwrite  = wb_wb_c.regwrite;
  assign wb_memtoreg  = wb_wb_c.memtoreg;
  assign wb_rd        = wb_rd_q;

  forwarding_unit #(.REG_AW(REG_AW)) u_fwd (
    .ex_rs1       (ex_rs1_q),
    .ex_rs2       (ex_rs2_q),
    .mem_rd       (mem_rd_q),
    .mem_regwrite (mem_wb_c.regwrite),
    .wb_rd        (wb_rd_q),
    .wb_regwrite  (wb_wb_c.regwrite),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline
// Randomized and directed stimulus for ctrl_pipeline, checked against a
// behavioural model of a three-slot instruction pipe (EX, MEM, WB).
module tb_ctrl_pipeline;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jsel;
    logic [1:0] aluop;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } instr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_jsel;
  logic [1:0] id_aluop;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic ex_redirect;
  logic ex_alusrc, ex_branch, ex_jsel, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
  logic [1:0] ex_aluop;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
  logic [REG_AW-1:0] mem_rd;
  logic wb_regwrite, wb_memtoreg;
  logic [REG_AW-1:0] wb_rd;
  logic stall, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  instr_t pipe [3];
  int stall_events;
  int flush_events;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_jsel(id_jsel), .id_aluop(id_aluop),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect),
    .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_jsel(ex_jsel),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_aluop(ex_aluop),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed === expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  function automatic logic loadUse(input instr_t id);
    return pipe[0].memread && (pipe[0].rd != 0) &&
           ((pipe[0].rd == id.rs1) || (pipe[0].rd == id.rs2));
  endfunction

  // Newest writer of the source register supplies it; x0 never forwards.
  function automatic logic [1:0] fwdModel(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (pipe[1].regwrite && pipe[1].rd == src) return 2'b10;
    if (pipe[2].regwrite && pipe[2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic applyStimulus(input instr_t ins, input logic redir);
    id_alusrc   = ins.alusrc;
    id_memtoreg = ins.memtoreg;
    id_regwrite = ins.regwrite;
    id_memread  = ins.memread;
    id_memwrite = ins.memwrite;
    id_branch   = ins.branch;
    id_jsel     = ins.jsel;
    id_aluop    = ins.aluop;
    id_rs1      = ins.rs1;
    id_rs2      = ins.rs2;
    id_rd       = ins.rd;
    ex_redirect = redir;
  endtask

  task automatic checkAll(input instr_t ins, input logic redir);
    logic hz;
    hz = loadUse(ins);
    checkOutput("stall",      32'(stall),      32'(hz && !redir));
    checkOutput("flush",      32'(flush),      32'(redir));
    checkOutput("fwd_a",      32'(fwd_a),      32'(fwdModel(pipe[0].rs1)));
    checkOutput("fwd_b",      32'(fwd_b),      32'(fwdModel(pipe[0].rs2)));
    checkOutput("ex_alusrc",  32'(ex_alusrc),  32'(pipe[0].alusrc));
    checkOutput("ex_aluop",   32'(ex_aluop),   32'(pipe[0].aluop));
    checkOutput("ex_branch",  32'(ex_branch),  32'(pipe[0].branch));
    checkOutput("ex_jsel",    32'(ex_jsel),    32'(pipe[0].jsel));
    checkOutput("ex_memread", 32'(ex_memread), 32'(pipe[0].memread));
    checkOutput("ex_memwrite",32'(ex_memwrite),32'(pipe[0].memwrite));
    checkOutput("ex_regwrite",32'(ex_regwrite),32'(pipe[0].regwrite));
    checkOutput("ex_memtoreg",32'(ex_memtoreg),32'(pipe[0].memtoreg));
    checkOutput("ex_rs1",     32'(ex_rs1),     32'(pipe[0].rs1));
    checkOutput("ex_rs2",     32'(ex_rs2),     32'(pipe[0].rs2));
    checkOutput("ex_rd",      32'(ex_rd),      32'(pipe[0].rd));
    checkOutput("mem_memread",32'(mem_memread),32'(pipe[1].memread));
    checkOutput("mem_memwrite",32'(mem_memwrite),32'(pipe[1].memwrite));
    checkOutput("mem_regwrite",32'(mem_regwrite),32'(pipe[1].regwrite));
    checkOutput("mem_memtoreg",32'(mem_memtoreg),32'(pipe[1].memtoreg));
    checkOutput("mem_rd",     32'(mem_rd),     32'(pipe[1].rd));
    checkOutput("wb_regwrite",32'(wb_regwrite),32'(pipe[2].regwrite));
    checkOutput("wb_memtoreg",32'(wb_memtoreg),32'(pipe[2].memtoreg));
    checkOutput("wb_rd",      32'(wb_rd),      32'(pipe[2].rd));
    checkOutput("stall_cnt",  32'(stall_cnt),  32'(sat(stall_events)));
    checkOutput("flush_cnt",  32'(flush_cnt),  32'(sat(flush_events)));
  endtask

  // Advance the model pipe as one clock edge would.
  task automatic modelStep(input instr_t ins, input logic redir);
    logic hz;
    hz = loadUse(ins);
    if (hz && !redir) stall_events++;
    if (redir) flush_events++;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (redir || hz) ? instr_t'('0) : ins;
  endtask

  task automatic runCycle(input instr_t ins, input logic redir);
    @(negedge clk);
    applyStimulus(ins, redir);
    #1;
    checkAll(ins, redir);
    @(posedge clk);
    modelStep(ins, redir);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    stall_events = 0;
    flush_events = 0;
  endtask

  // Reset is pulled between edges and must clear outputs before any edge.
  task automatic doReset();
    instr_t idle;
    idle = '0;
    @(negedge clk);
    applyStimulus(idle, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    clearModel();
    checkAll(idle, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic instr_t randInstr();
    instr_t r;
    r = instr_t'($urandom);
    r.memread = ($urandom_range(0, 2) == 0);
    r.rs1 = 5'($urandom_range(0, 3));
    r.rs2 = 5'($urandom_range(0, 3));
    r.rd  = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    instr_t ins;
    instr_t rtype;
    instr_t load;
    clearModel();
    ins = '0;
    applyStimulus(ins, 1'b0);
    #3;
    checkAll(ins, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Random traffic with a small register range so hazards and forwards
    // are common; occasional mid-stream resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0)
        doReset();
      else
        runCycle(randInstr(), ($urandom_range(0, 5) == 0));
    end

    // Fill the pipe with R-type writes to x9, reset between edges, then
    // check a fresh write to x9 walks through all stages.
    rtype = '0;
    rtype.regwrite = 1'b1;
    rtype.aluop = 2'b10;
    rtype.rs1 = 5'd1;
    rtype.rs2 = 5'd2;
    rtype.rd = 5'd9;
    for (int c = 0; c < 4; c++) runCycle(rtype, 1'b0);
    doReset();
    for (int c = 0; c < 3; c++) runCycle(rtype, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("reset_walk_wb_rd", 32'(wb_rd), 32'd9);

    // Back-to-back dependent loads: one stall every other cycle, driving
    // the stall counter past its saturation point.
    doReset();
    load = '0;
    load.memread = 1'b1;
    load.regwrite = 1'b1;
    load.memtoreg = 1'b1;
    load.rs1 = 5'd5;
    load.rd = 5'd5;
    for (int c = 0; c < 42; c++) runCycle(load, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("stall_cnt_saturated", 32'(stall_cnt), 32'(CNT_MAX));

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
